// File: rtl/drv_ad56x3_pkg.sv
// Shared constants, frame-length helper and sample-pair type for the AD56x3 DAC path.
package drv_ad56x3_pkg;

    localparam int SHIFT_WIDTH  = 24;
    localparam int SAMPLE_WIDTH = 14;

    // Serial frame length of the driver in clk cycles; sets the minimum update period.
    function automatic int frame_cycles(input int sclkDiv, input int syncDur);
        return sclkDiv * (2 * SHIFT_WIDTH + syncDur + 1);
    endfunction

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] a;
        logic [SAMPLE_WIDTH-1:0] b;
    } samplePair_t;

endpackage

// File: rtl/dac_sample_scheduler_if.sv
// Valid/ready stream carrying one A/B sample pair per beat.
interface dac_sample_scheduler_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  sValid;
    logic                  sReady;
    logic [DATA_WIDTH-1:0] sDataA;
    logic [DATA_WIDTH-1:0] sDataB;

    modport master (output sValid, output sDataA, output sDataB, input  sReady);
    modport slave  (input  sValid, input  sDataA, input  sDataB, output sReady);
endinterface

// File: rtl/dac_sample_fifo.sv
// Synchronous FIFO for sample pairs with an exact registered fill level.
module dac_sample_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic             doPush, doPop;

    assign full   = (level == LW'(DEPTH));
    assign empty  = (level == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces buffered A/B sample pairs to the DAC driver: one ce strobe per update period.
module dac_sample_scheduler
    import drv_ad56x3_pkg::*;
#(
    parameter int DATA_WIDTH   = SAMPLE_WIDTH,
    parameter int FIFO_DEPTH   = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int MIN_PERIOD   = frame_cycles(2, 5),
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    dac_sample_scheduler_if.slave   s,
    output logic                    ce,
    output logic [DATA_WIDTH-1:0]   dataA,
    output logic [DATA_WIDTH-1:0]   dataB,
    output logic                    underflow,
    output logic [LW-1:0]           fillLevel
);

    localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);

    logic [PERIOD_WIDTH-1:0]   cnt, curPeriod, effPeriod;
    logic                      tick, push, pop, full, empty;
    logic [2*DATA_WIDTH-1:0]   head;

    assign effPeriod = (period < MIN_P) ? MIN_P : period;
    assign tick      = enable && (cnt == curPeriod - 1'b1);
    assign s.sReady  = ~full;
    assign push      = s.sValid && !full;
    assign pop       = tick && !empty;

    // Period is latched while idle and at each wrap, so a change never shortens a running count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            curPeriod <= MIN_P;
        end else if (!enable) begin
            cnt       <= '0;
            curPeriod <= effPeriod;
        end else if (tick) begin
            cnt       <= '0;
            curPeriod <= effPeriod;
        end else begin
            cnt       <= cnt + 1'b1;
        end
    end

    dac_sample_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wrData ({s.sDataA, s.sDataB}),
        .rdData (head),
        .full   (full),
        .empty  (empty),
        .level  (fillLevel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce        <= 1'b0;
            underflow <= 1'b0;
            dataA     <= '0;
            dataB     <= '0;
        end else begin
            ce        <= pop;
            underflow <= tick && empty;
            if (pop) begin
                dataA <= head[2*DATA_WIDTH-1:DATA_WIDTH];
                dataB <= head[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: pacing, clamping, full FIFO, push+pop, reset, long stream.
module tb_dac_sample_scheduler;
    import drv_ad56x3_pkg::*;

    localparam int DW   = 14;
    localparam int DEP  = 16;
    localparam int PW   = 16;
    localparam int MINP = frame_cycles(2, 5);  // 108

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [PW-1:0] period = '0;
    logic          ce, underflow;
    logic [DW-1:0] dataA, dataB;
    logic [4:0]    fillLevel;

    dac_sample_scheduler_if #(.DATA_WIDTH(DW)) sif ();

    dac_sample_scheduler #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .PERIOD_WIDTH(PW), .MIN_PERIOD(MINP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period), .s(sif),
        .ce(ce), .dataA(dataA), .dataB(dataB), .underflow(underflow), .fillLevel(fillLevel)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushPair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        sif.sValid = 1'b1;
        sif.sDataA = a;
        sif.sDataB = b;
        step();
        sif.sValid = 1'b0;
    endtask

    samplePair_t q[$];
    samplePair_t p, e;
    int ceAt, nCe, nUf, uf1, uf2, acc, push17, lastCe, nGot, pushed;
    logic [DW-1:0] gotA, gotB;
    logic rdy, sv;

    initial begin
        sif.sValid = 1'b0;
        sif.sDataA = '0;
        sif.sDataB = '0;
        step(); step();
        reset = 1'b0;
        step();

        // reset state
        chk("rst_ce", ce, 0);
        chk("rst_dataA", dataA, 0);
        chk("rst_dataB", dataB, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_fill", fillLevel, 0);
        chk("rst_ready", sif.sReady, 1);

        // 1: single pair, period 200; ce in cycle 200 counting the first enabled cycle as 0
        period = 16'd200;
        pushPair(14'h1234, 14'h0ABC);
        chk("t1_fill", fillLevel, 1);
        enable = 1'b1;
        ceAt = -1; nCe = 0; nUf = 0; uf1 = -1; uf2 = -1;
        for (int i = 1; i <= 650; i++) begin
            step();
            if (ce) begin
                nCe++;
                if (ceAt < 0) begin ceAt = i; gotA = dataA; gotB = dataB; end
            end
            if (underflow) begin
                nUf++;
                if (nUf == 1) uf1 = i; else if (nUf == 2) uf2 = i;
            end
        end
        chk("t1_ceAt", ceAt, 200);
        chk("t1_dataA", gotA, 14'h1234);
        chk("t1_dataB", gotB, 14'h0ABC);
        chk("t1_nCe", nCe, 1);
        chk("t1_uf1", uf1, 400);
        chk("t1_uf2", uf2, 600);
        chk("t1_nUf", nUf, 2);
        chk("t1_hold", dataA, 14'h1234);

        // 2: period below minimum clamps to 108
        enable = 1'b0;
        period = 16'd10;
        step();
        for (int j = 0; j < 4; j++) pushPair(DW'(14'h100 + j), DW'(14'h200 + j));
        chk("t2_fill4", fillLevel, 4);
        enable = 1'b1;
        nCe = 0;
        for (int i = 1; i <= 500; i++) begin
            step();
            if (ce) begin
                chk("t2_ceT", i, 108 * (nCe + 1));
                chk("t2_dA", dataA, 14'h100 + nCe);
                chk("t2_dB", dataB, 14'h200 + nCe);
                nCe++;
            end
        end
        chk("t2_nCe", nCe, 4);
        chk("t2_fill0", fillLevel, 0);

        // 3: 17 back-to-back pushes while paused
        enable = 1'b0;
        step();
        sif.sValid = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            sif.sDataA = DW'(acc);
            sif.sDataB = DW'(acc + 14'h100);
            rdy = sif.sReady;
            step();
            if (rdy) acc++;
        end
        chk("t3_acc", acc, 16);
        chk("t3_fill16", fillLevel, 16);
        chk("t3_ready0", sif.sReady, 0);
        period = 16'd108;
        enable = 1'b1;
        ceAt = -1; push17 = -1;
        for (int i = 1; i <= 120; i++) begin
            rdy = sif.sReady;
            step();
            if (ce && ceAt < 0) begin ceAt = i; gotA = dataA; gotB = dataB; end
            if (rdy && push17 < 0) push17 = i;
        end
        sif.sValid = 1'b0;
        enable = 1'b0;
        chk("t3_ceAt", ceAt, 108);
        chk("t3_dA", gotA, 0);
        chk("t3_dB", gotB, 14'h100);
        chk("t3_push17", push17, 109);
        chk("t3_fillEnd", fillLevel, 16);

        // 4: push lands on the tick that pops, at fill 5
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("t4_fillRst", fillLevel, 0);
        for (int j = 0; j < 5; j++) pushPair(DW'(14'h50 + j), DW'(14'h60 + j));
        enable = 1'b1;
        repeat (107) step();
        pushPair(14'h3AA, 14'h155);
        chk("t4_ce", ce, 1);
        chk("t4_dA", dataA, 14'h50);
        chk("t4_dB", dataB, 14'h60);
        chk("t4_fill5", fillLevel, 5);

        // 5: reset while fill=8 and a tick is pending
        for (int j = 0; j < 3; j++) pushPair(DW'(14'h70 + j), DW'(14'h80 + j));
        chk("t5_fill8", fillLevel, 8);
        repeat (215 - 111) step();
        reset = 1'b1;
        #1;
        chk("t5_ce", ce, 0);
        chk("t5_dA", dataA, 0);
        chk("t5_dB", dataB, 0);
        chk("t5_uf", underflow, 0);
        chk("t5_fill", fillLevel, 0);
        chk("t5_ready", sif.sReady, 1);
        step();
        reset = 1'b0;
        nCe = 0;
        repeat (20) begin step(); if (ce) nCe++; end
        chk("t5_noCe", nCe, 0);

        // 6: long random stream at period 150, checked against a scoreboard
        enable = 1'b0;
        period = 16'd150;
        step();
        enable = 1'b1;
        pushed = 0; nGot = 0; nUf = 0; lastCe = -1;
        for (int i = 1; i <= 15300; i++) begin
            if (pushed < 100) begin
                p.a = DW'($urandom_range(0, 16383));
                p.b = DW'($urandom_range(0, 16383));
                sif.sValid = 1'b1;
                sif.sDataA = p.a;
                sif.sDataB = p.b;
            end else begin
                sif.sValid = 1'b0;
            end
            sv  = sif.sValid;
            rdy = sif.sReady;
            step();
            if (sv && rdy) begin q.push_back(p); pushed++; end
            if (ce) begin
                if (q.size() == 0) chk("t6_spurious", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("t6_dA", dataA, e.a);
                    chk("t6_dB", dataB, e.b);
                    if (lastCe >= 0) chk("t6_gap", i - lastCe, 150);
                    lastCe = i;
                    nGot++;
                end
            end
            if (underflow && nGot < 100) nUf++;
        end
        sif.sValid = 1'b0;
        chk("t6_nGot", nGot, 100);
        chk("t6_nUf", nUf, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
